// File: rtl/fft_bfly_pkg.sv
// Shared types, constants and saturating helpers for the pipelined radix-2 butterfly.
// Helpers work on 64-bit signed values; callers narrow the result to the target width.
package fft_bfly_pkg;

    typedef enum logic [1:0] {
        SCALE_NONE  = 2'd0,
        SCALE_FIXED = 2'd1,
        SCALE_BFP   = 2'd2
    } scale_mode_e;

    localparam int LATENCY = 3;

    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

    // Negating the most negative w-bit value lands on the most positive one.
    function automatic logic signed [63:0] neg_sat(input logic signed [63:0] x, input int w);
        return sat_to_width(-x, w);
    endfunction

endpackage

// File: rtl/fft_bfly_pipe_cmul.sv
// Two-stage complex multiply t = in1 * W (W conjugated for IFFT), advancing only on en.
// FFT_BFLY_ROUND_EN: round half-up on the shift back to sample scale, else truncate toward -inf.
module fft_cmul_pipe
    import fft_bfly_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         fft_ifft,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    output logic signed [DATA_WIDTH:0]   t_r,
    output logic signed [DATA_WIDTH:0]   t_i
);
    localparam int PW = DATA_WIDTH + TW_WIDTH;

`ifdef FFT_BFLY_ROUND_EN
    localparam logic signed [PW:0] RND = (PW + 1)'(64'd1 << (TW_WIDTH - 2));
`else
    localparam logic signed [PW:0] RND = '0;
`endif

    logic signed [TW_WIDTH-1:0] f;
    logic signed [PW-1:0]       c_x, d_x, e_x, f_x;
    logic signed [PW-1:0]       ce, cf, de, df;
    logic signed [PW:0]         sum_r, sum_i;

    assign f   = fft_ifft ? TW_WIDTH'(neg_sat({{(64 - TW_WIDTH){tw_i[TW_WIDTH-1]}}, tw_i}, TW_WIDTH))
                          : tw_i;
    assign c_x = {{TW_WIDTH{c[DATA_WIDTH-1]}}, c};
    assign d_x = {{TW_WIDTH{d[DATA_WIDTH-1]}}, d};
    assign e_x = {{DATA_WIDTH{tw_r[TW_WIDTH-1]}}, tw_r};
    assign f_x = {{DATA_WIDTH{f[TW_WIDTH-1]}}, f};

    // One guard bit: CE - DF can exceed a single product's range when both operands are -1.0.
    assign sum_r = {ce[PW-1], ce} - {df[PW-1], df} + RND;
    assign sum_i = {cf[PW-1], cf} + {de[PW-1], de} + RND;

    always_ff @(posedge clk) begin
        if (rst) begin
            ce  <= '0;
            cf  <= '0;
            de  <= '0;
            df  <= '0;
            t_r <= '0;
            t_i <= '0;
        end else if (en) begin
            ce  <= c_x * e_x;
            cf  <= c_x * f_x;
            de  <= d_x * e_x;
            df  <= d_x * f_x;
            t_r <= (DATA_WIDTH + 1)'(sum_r >>> (TW_WIDTH - 1));
            t_i <= (DATA_WIDTH + 1)'(sum_i >>> (TW_WIDTH - 1));
        end
    end

endmodule

// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIT butterfly out0 = in0 + W*in1, out1 = in0 - W*in1; 3-cycle latency, 1 beat/cycle.
// Whole pipe stalls while out_valid & !out_ready (in_ready = en); FFT_BFLY_ROUND_EN enables rounding.
module fft_bfly_pipe
    import fft_bfly_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fft_ifft,
    input  logic [1:0]                   scale_mode,
    input  logic                         clr_sat,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in0_r,
    input  logic signed [DATA_WIDTH-1:0] in0_i,
    input  logic signed [DATA_WIDTH-1:0] in1_r,
    input  logic signed [DATA_WIDTH-1:0] in1_i,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out0_r,
    output logic signed [DATA_WIDTH-1:0] out0_i,
    output logic signed [DATA_WIDTH-1:0] out1_r,
    output logic signed [DATA_WIDTH-1:0] out1_i,
    output logic                         out_scaled,
    output logic                         sat_sticky
);
    localparam int SW = DATA_WIDTH + 2;

`ifdef FFT_BFLY_ROUND_EN
    localparam logic signed [SW-1:0] HALF = SW'(1);
`else
    localparam logic signed [SW-1:0] HALF = '0;
`endif

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    logic                         en;
    logic                         s1_vld, s2_vld;
    cplx_t                        s1_in0, s2_in0;
    scale_mode_e                  mode_in, s1_mode, s2_mode;
    logic signed [DATA_WIDTH:0]   t_r, t_i;
    logic signed [SW-1:0]         in0r_x, in0i_x, tr_x, ti_x;
    logic signed [SW-1:0]         sum [4];
    logic signed [SW-1:0]         scl [4];
    logic signed [DATA_WIDTH-1:0] res [4];
    logic                         over, do_shift, sat_hit;

    function automatic logic fits(input logic signed [SW-1:0] v);
        logic signed [63:0] x;
        x = {{(64 - SW){v[SW-1]}}, v};
        return sat_to_width(x, DATA_WIDTH) == x;
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        case (scale_mode)
            2'd1:    mode_in = SCALE_FIXED;
            2'd2:    mode_in = SCALE_BFP;
            default: mode_in = SCALE_NONE;
        endcase
    end

    fft_cmul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .TW_WIDTH   (TW_WIDTH)
    ) u_cmul (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .fft_ifft (fft_ifft),
        .c        (in1_r),
        .d        (in1_i),
        .tw_r     (tw_r),
        .tw_i     (tw_i),
        .t_r      (t_r),
        .t_i      (t_i)
    );

    // in0 and mode ride alongside the multiplier so they meet t in S3.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_in0  <= '0;
            s2_in0  <= '0;
            s1_mode <= SCALE_NONE;
            s2_mode <= SCALE_NONE;
        end else if (en) begin
            s1_vld  <= in_valid;
            s1_in0  <= {in0_r, in0_i};
            s1_mode <= mode_in;
            s2_vld  <= s1_vld;
            s2_in0  <= s1_in0;
            s2_mode <= s1_mode;
        end
    end

    always_comb begin
        in0r_x   = {{2{s2_in0.re[DATA_WIDTH-1]}}, s2_in0.re};
        in0i_x   = {{2{s2_in0.im[DATA_WIDTH-1]}}, s2_in0.im};
        tr_x     = {t_r[DATA_WIDTH], t_r};
        ti_x     = {t_i[DATA_WIDTH], t_i};
        sum[0]   = in0r_x + tr_x;
        sum[1]   = in0i_x + ti_x;
        sum[2]   = in0r_x - tr_x;
        sum[3]   = in0i_x - ti_x;
        over     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!fits(sum[k])) over = 1'b1;
        end
        // Block floating point: one shared shift decision for all four components.
        do_shift = (s2_mode == SCALE_FIXED) || ((s2_mode == SCALE_BFP) && over);
        sat_hit  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scl[k] = do_shift ? ((sum[k] + HALF) >>> 1) : sum[k];
            if (!fits(scl[k])) sat_hit = 1'b1;
            res[k] = DATA_WIDTH'(sat_to_width({{(64 - SW){scl[k][SW-1]}}, scl[k]}, DATA_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out0_r     <= '0;
            out0_i     <= '0;
            out1_r     <= '0;
            out1_i     <= '0;
            out_scaled <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= s2_vld;
                if (s2_vld) begin
                    out0_r     <= res[0];
                    out0_i     <= res[1];
                    out1_r     <= res[2];
                    out1_i     <= res[3];
                    out_scaled <= do_shift;
                end
            end
            if (en && s2_vld && sat_hit) begin
                sat_sticky <= 1'b1;
            end else if (clr_sat) begin
                sat_sticky <= 1'b0;
            end
        end
    end

endmodule
